// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encoding, frame width and
// the bit-period calculation used by both directions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_bit_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. Free-runs with period BIT_TICKS; load restarts a
// full period, half_load restarts a half period so the next tick lands mid-bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half_load,
  output logic tick
);

  localparam int CNT_W = $clog2(BIT_TICKS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BIT_TICKS / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load)                cnt_d = FULL;
    else if (half_load)      cnt_d = HALF;
    else if (cnt_q == '0)    cnt_d = FULL;
    else                     cnt_d = cnt_q - CNT_W'(1);
  end

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmit and receive FSMs, each paced by
// its own bit timer, sharing only the system clock and reset.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_data_valid,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_data_valid
);

  localparam int BIT_TICKS = calc_bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic                 tx_load, tx_tick;

  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                 rx_meta_q, rx_sync_q;
  logic                 rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic                 rx_half_load, rx_tick;

  uart_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_tx_timer (
    .clk(clk), .rst(rst), .load(tx_load), .half_load(1'b0), .tick(tx_tick)
  );

  uart_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_rx_timer (
    .clk(clk), .rst(rst), .load(1'b0), .half_load(rx_half_load), .tick(rx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      IDLE: if (tx_data_valid) begin
        tx_state_d = START;
        tx_shift_d = tx_data_in;
        tx_idx_d   = '0;
        tx_d       = 1'b0;
        tx_busy_d  = 1'b1;
        tx_load    = 1'b1;
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_d       = tx_shift_q[0];
      end
      DATA: if (tx_tick) begin
        if (tx_idx_q == LAST_IDX) begin
          tx_state_d = STOP;
          tx_d       = 1'b1;
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + IDX_W'(1);
          tx_d       = tx_shift_d[0];
        end
      end
      STOP: if (tx_tick) begin
        tx_state_d = IDLE;
        tx_busy_d  = 1'b0;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // A failed stop bit parks in STOP with rx_err set until the line recovers,
  // so a held break cannot look like a fresh start bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_idx_d     = rx_idx_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_err_d     = rx_err_q;
    rx_half_load = 1'b0;
    case (rx_state_q)
      IDLE: if (!rx_sync_q) begin
        rx_state_d   = START;
        rx_half_load = 1'b1;
        rx_err_d     = 1'b0;
      end
      START: if (rx_tick) begin
        rx_state_d = rx_sync_q ? IDLE : DATA;
        rx_idx_d   = '0;
      end
      DATA: if (rx_tick) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == LAST_IDX) rx_state_d = STOP;
        else                      rx_idx_d   = rx_idx_q + IDX_W'(1);
      end
      STOP: begin
        if (rx_err_q) begin
          if (rx_sync_q) rx_state_d = IDLE;
        end else if (rx_tick) begin
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = IDLE;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_idx_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  assign tx            = tx_q;
  assign tx_busy       = tx_busy_q;
  assign rx_data_out   = rx_data_q;
  assign rx_data_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver at the default 100 MHz / 115200 baud,
// using loopback and a directly driven rx line against a frame-level model.
module tb_uart_transceiver;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 115200;
  localparam int BT        = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       rx_data_valid;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;

  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .tx_data_in(tx_data_in), .tx_data_valid(tx_data_valid),
    .tx(tx), .tx_busy(tx_busy), .rx(rx), .rx_data_out(rx_data_out),
    .rx_data_valid(rx_data_valid)
  );

  always @(negedge clk) if (rx_data_valid === 1'b1) got_q.push_back(rx_data_out);

  // Line level of bit i (0..9) of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Returns on the first negedge at which tx is low (start of the start bit).
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data_in    = b;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_data_in    = 8'($urandom);
  endtask

  task automatic wait_busy_low(input string name);
    for (int i = 0; i < 12 * BT && tx_busy !== 1'b0; i++) @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: tx_busy=%b still, want 0", name, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #100;
    n_checks += 4;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    if (rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_data_valid); end
    if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data_out); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    int busy_len;
    loop_en = 1'b1;
    got_q.delete();
    send_byte(8'h9B);
    busy_len = 0;
    for (int i = 0; i < 12 * BT && tx_busy === 1'b1; i++) begin
      busy_len++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_checks += 3;
    if (busy_len != 10 * BT) begin n_fail++; $display("FAIL loop_busy_len: got %0d want %0d", busy_len, 10 * BT); end
    if (got_q.size() != 1 || got_q[0] !== 8'h9B) begin
      n_fail++; $display("FAIL loop_rx: got %0d pulses first %h want 1 pulse 9b", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    end
    if (rx_data_out !== 8'h9B) begin n_fail++; $display("FAIL loop_rx_data: got %h want 9b", rx_data_out); end
  endtask

  task automatic test_bit_timing(input logic [7:0] b);
    int bad;
    loop_en = 1'b1;
    got_q.delete();
    send_byte(b);
    for (int i = 0; i < 4 && tx !== 1'b0; i++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < BT; c++) begin
        if (tx !== frame_bit(b, k)) bad++;
        @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL timing_bit%0d: %0d of %0d cycles wrong, want level %b", k, bad, BT, frame_bit(b, k));
      end
    end
    n_checks += 3;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL timing_end: tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
    end
    if (got_q.size() != 1) begin n_fail++; $display("FAIL timing_rx_count: got %0d want 1", got_q.size()); end
    if (rx_data_out !== b) begin n_fail++; $display("FAIL timing_rx_data: got %h want %h", rx_data_out, b); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int bad;
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF};
    loop_en = 1'b1;
    got_q.delete();
    @(negedge clk);
    tx_data_in    = 8'h00;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_in = 8'hFF;
    wait_busy_low("b2b_first");
    gap = 0;
    for (int i = 0; i < 10 && tx_busy !== 1'b1; i++) begin
      gap++;
      @(negedge clk);
    end
    n_checks++;
    if (gap != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles want 1", gap); end
    tx_data_in = 8'h55;
    repeat (4 * BT) @(negedge clk);
    tx_data_valid = 1'b0;
    wait_busy_low("b2b_second");
    bad = 0;
    for (int c = 0; c < 2 * BT; c++) begin
      if (tx_busy !== 1'b0 || tx !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks += 2;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_no_third: %0d busy/low cycles after second frame want 0", bad); end
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_rx_glitch();
    logic [7:0] prev;
    prev = rx_data_out;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    got_q.delete();
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BT) @(negedge clk);
    n_checks += 2;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", got_q.size()); end
    if (rx_data_out !== prev) begin n_fail++; $display("FAIL glitch_data: got %h want %h", rx_data_out, prev); end
  endtask

  // Bad-stop frame plus break, then a good frame on rx, while tx sends an unrelated byte.
  task automatic test_framing();
    logic [7:0] bad_b, good_b, tx_b, prev;
    bad_b  = 8'($urandom);
    good_b = 8'($urandom);
    tx_b   = 8'($urandom);
    prev   = rx_data_out;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    got_q.delete();
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          rx_drv = frame_bit(bad_b, k);
          repeat (BT) @(negedge clk);
        end
        rx_drv = 1'b0;
        repeat (2 * BT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BT) @(negedge clk);
        n_checks += 2;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL framing_pulses: got %0d want 0", got_q.size()); end
        if (rx_data_out !== prev) begin n_fail++; $display("FAIL framing_data_kept: got %h want %h", rx_data_out, prev); end
        for (int k = 0; k < 10; k++) begin
          rx_drv = frame_bit(good_b, k);
          repeat (BT) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
      end
      begin
        logic [7:0] dec;
        logic dec_stop;
        dec = 8'h00;
        dec_stop = 1'b0;
        send_byte(tx_b);
        repeat (BT / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          if (k >= 1 && k <= 8) dec[k-1] = tx;
          if (k == 9) dec_stop = tx;
          repeat (BT) @(negedge clk);
        end
        n_checks += 2;
        if (dec !== tx_b) begin n_fail++; $display("FAIL duplex_tx_byte: got %h want %h", dec, tx_b); end
        if (dec_stop !== 1'b1) begin n_fail++; $display("FAIL duplex_tx_stop: got %b want 1", dec_stop); end
      end
    join
    n_checks += 2;
    if (got_q.size() != 1 || got_q[0] !== good_b) begin
      n_fail++; $display("FAIL recover_rx: got %0d pulses first %h want 1 pulse %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, good_b);
    end
    if (rx_data_out !== good_b) begin n_fail++; $display("FAIL recover_rx_data: got %h want %h", rx_data_out, good_b); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'($urandom);
    loop_en = 1'b1;
    got_q.delete();
    send_byte(b);
    repeat (5 * BT + BT / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks += 3;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    if (rx_data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h want 00", rx_data_out); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_partial: got %0d pulses want 0", got_q.size()); end
    got_q.delete();
    send_byte(8'h3C);
    wait_busy_low("midrst_after");
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      n_fail++; $display("FAIL midrst_rx: got %0d pulses first %h want 1 pulse 3c", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    end
    if (rx_data_out !== 8'h3C) begin n_fail++; $display("FAIL midrst_rx_data: got %h want 3c", rx_data_out); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_bit_timing(8'hA5);
    test_back_to_back();
    test_rx_glitch();
    test_framing();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
